vga_scroll_pattern_gen: RTL and testbench

// - Parametrised VGA test-pattern source that drives the TinyVGA PMOD. It owns the 640x480 timing

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen.sv | 51 +++++
 rtl/vga_scroll_pattern_gen.sv | 131 +++++++++++++
 tb/tb_vga_scroll_pattern_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pattern select encoding and the timing bundle
// passed from the counter block to the pattern stage.
package vga_pkg;

  localparam int unsigned H_DISP  = 640;
  localparam int unsigned H_FP    = 16;
  localparam int unsigned H_SYNC  = 96;
  localparam int unsigned H_BP    = 48;
  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_DISP  = 480;
  localparam int unsigned V_FP    = 10;
  localparam int unsigned V_SYNC  = 2;
  localparam int unsigned V_BP    = 33;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned FCNT_W  = 8;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_XOR   = 2'd2,
    PAT_CYCLE = 2'd3
  } pattern_mode_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
    logic frame_tick;
  } timing_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for one VGA mode plus the unregistered sync, blanking and
// start-of-vblank strobe decoded from them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP = vga_pkg::H_DISP,
  parameter int unsigned H_FP   = vga_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_pkg::H_BP,
  parameter int unsigned V_DISP = vga_pkg::V_DISP,
  parameter int unsigned V_FP   = vga_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output timing_t          timing_c
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_DISP + H_FP;
  localparam int unsigned HS_END  = H_DISP + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_DISP + V_FP;
  localparam int unsigned VS_END  = V_DISP + V_FP + V_SYNC;

  // Pixel/line counters; vpos advances on the last pixel of each line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == POS_W'(H_TOTAL - 1)) begin
      hpos <= '0;
      if (vpos == POS_W'(V_TOTAL - 1)) vpos <= '0;
      else                             vpos <= vpos + POS_W'(1);
    end else begin
      hpos <= hpos + POS_W'(1);
    end
  end

  always_comb begin
    timing_c            = '0;
    timing_c.hsync      = !((hpos >= POS_W'(HS_BEG)) && (hpos < POS_W'(HS_END)));
    timing_c.vsync      = !((vpos >= POS_W'(VS_BEG)) && (vpos < POS_W'(VS_END)));
    timing_c.display_on = (hpos < POS_W'(H_DISP)) && (vpos < POS_W'(V_DISP));
    timing_c.frame_tick = (hpos == '0) && (vpos == POS_W'(V_DISP));
  end

endmodule

// File: rtl/vga_scroll_pattern_gen.sv
// Scrolling VGA test-pattern source: per-frame scroll/mode state, pattern
// generation and a single output register stage keeping sync and colour aligned.
module vga_scroll_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned CW     = 2,
  parameter int unsigned OFS_W  = 10,
  parameter int unsigned H_DISP = vga_pkg::H_DISP,
  parameter int unsigned H_FP   = vga_pkg::H_FP,
  parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
  parameter int unsigned H_BP   = vga_pkg::H_BP,
  parameter int unsigned V_DISP = vga_pkg::V_DISP,
  parameter int unsigned V_FP   = vga_pkg::V_FP,
  parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
  parameter int unsigned V_BP   = vga_pkg::V_BP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [2:0]        speed,
  input  logic              dir,
  input  logic              pause,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [CW-1:0]     r,
  output logic [CW-1:0]     g,
  output logic [CW-1:0]     b,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  timing_t          tim_c;
  logic [OFS_W-1:0] offset;
  pattern_mode_e    mode_q;
  logic [OFS_W-1:0] sx_c;
  logic [7:0]       xor_c;
  logic             check_c;
  logic [CW-1:0]    r_c;
  logic [CW-1:0]    g_c;
  logic [CW-1:0]    b_c;

  vga_timing_gen #(
    .H_DISP (H_DISP),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_DISP (V_DISP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .hpos     (hpos),
    .vpos     (vpos),
    .timing_c (tim_c)
  );

  // Frame-rate state only moves in vblank so a frame is never drawn half old, half new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset    <= '0;
      frame_cnt <= '0;
      mode_q    <= PAT_BARS;
    end else if (tim_c.frame_tick) begin
      mode_q <= pattern_mode_e'(mode);
      if (!pause) begin
        offset    <= dir ? (offset - OFS_W'(speed)) : (offset + OFS_W'(speed));
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

  always_comb begin
    sx_c    = OFS_W'(hpos) + offset;
    xor_c   = 8'(sx_c) ^ 8'(vpos);
    check_c = 1'(sx_c >> 5) ^ 1'(vpos >> 5);
    r_c     = '0;
    g_c     = '0;
    b_c     = '0;
    case (mode_q)
      PAT_BARS: begin
        r_c = CW'(sx_c >> 5);
        g_c = CW'(sx_c >> 6);
        b_c = CW'(sx_c >> 7);
      end
      PAT_CHECK: begin
        r_c = {CW{check_c}};
        g_c = {CW{check_c}};
        b_c = {CW{check_c}};
      end
      PAT_XOR: begin
        r_c = CW'(xor_c >> (8 - CW));
        g_c = CW'(xor_c >> (6 - CW));
        b_c = CW'(xor_c >> (4 - CW));
      end
      PAT_CYCLE: begin
        r_c = CW'(frame_cnt >> (8 - CW));
        g_c = CW'(frame_cnt >> (6 - CW));
        b_c = CW'(frame_cnt >> (4 - CW));
      end
      default: ;
    endcase
    if (!tim_c.display_on) begin
      r_c = '0;
      g_c = '0;
      b_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
    end else begin
      hsync      <= tim_c.hsync;
      vsync      <= tim_c.vsync;
      display_on <= tim_c.display_on;
      r          <= r_c;
      g          <= g_c;
      b          <= b_c;
    end
  end

endmodule

// File: tb/tb_vga_scroll_pattern_gen.sv
// Bench for vga_scroll_pattern_gen on a shrunken raster: a cycle-indexed reference
// model predicts every output word, which is queued and compared one clock later.
module tb_vga_scroll_pattern_gen;

  localparam int HD = 10, HFP = 1, HS = 3, HBP = 2, HT = HD + HFP + HS + HBP;
  localparam int VD = 5,  VFP = 1, VS = 2, VBP = 1, VT = VD + VFP + VS + VBP;
  localparam int F  = HT * VT;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [2:0]    speed = 3'd0;
  logic          dir = 1'b0;
  logic          pause = 1'b0;
  logic          hsync, vsync, display_on;
  logic [CW-1:0] r, g, b;
  logic [7:0]    frame_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int m_t, m_off, m_fc, m_mode;
  int cyc, first_hs, n_hs, n_vs, n_de;
  logic [16:0] exp_q[$];

  vga_scroll_pattern_gen #(
    .CW(CW), .OFS_W(10),
    .H_DISP(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISP(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .dir(dir), .pause(pause),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .r(r), .g(g), .b(b), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference picture: {hsync, vsync, display_on, r, g, b} for raster point (h, v).
  function automatic logic [8:0] model_pix(int h, int v, int off, int md, int fc);
    logic hs_e, vs_e, de_e;
    int sx, x, rr, gg, bb;
    hs_e = !((h >= HD + HFP) && (h < HD + HFP + HS));
    vs_e = !((v >= VD + VFP) && (v < VD + VFP + VS));
    de_e = (h < HD) && (v < VD);
    sx = (h + off) % 1024;
    rr = 0; gg = 0; bb = 0;
    case (md)
      0: begin rr = (sx >> 5) & 3; gg = (sx >> 6) & 3; bb = (sx >> 7) & 3; end
      1: begin x = ((sx >> 5) ^ (v >> 5)) & 1; rr = x * 3; gg = x * 3; bb = x * 3; end
      2: begin x = (sx ^ v) & 255; rr = x >> 6; gg = (x >> 4) & 3; bb = (x >> 2) & 3; end
      default: begin rr = (fc >> 6) & 3; gg = (fc >> 4) & 3; bb = (fc >> 2) & 3; end
    endcase
    if (!de_e) begin rr = 0; gg = 0; bb = 0; end
    return {hs_e, vs_e, de_e, 2'(rr), 2'(gg), 2'(bb)};
  endfunction

  // One clock: predict the word the coming edge registers, then compare last prediction.
  task automatic step();
    int h, v;
    logic [8:0] pix;
    h = m_t % HT;
    v = (m_t / HT) % VT;
    pix = model_pix(h, v, m_off, m_mode, m_fc);
    if (h == 0 && v == VD) begin
      m_mode = int'(mode);
      if (!pause) begin
        m_off = dir ? ((m_off - int'(speed)) & 1023) : ((m_off + int'(speed)) & 1023);
        m_fc  = (m_fc + 1) & 255;
      end
    end
    exp_q.push_back({pix, 8'(m_fc)});
    m_t++;
    @(posedge clk); #1;
    if (exp_q.size() > 0)
      check("pix", 32'({hsync, vsync, display_on, r, g, b, frame_cnt}), 32'(exp_q.pop_front()));
    cyc++;
    if (!hsync) n_hs++;
    if (!vsync) n_vs++;
    if (display_on) n_de++;
    if (!hsync && first_hs == 0) first_hs = cyc;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({hsync, vsync, display_on, r, g, b, frame_cnt}), 32'h18000);
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold", 32'({hsync, vsync, display_on, r, g, b, frame_cnt}), 32'h18000);
    rst_n = 1'b1;
    exp_q.delete();
    m_t = 0; m_off = 0; m_fc = 0; m_mode = 0;
    cyc = 0; first_hs = 0; n_hs = 0; n_vs = 0; n_de = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n_red, n_lit, k;
    @(posedge clk); #1;
    do_reset(3);
    run(37);
    do_reset(5);

    // Raster timing over two frames, first hsync right after release
    run(2 * F);
    check("first_hs", 32'(first_hs), 32'(HD + HFP + 1));
    check("hs_low", 32'(n_hs), 32'(2 * VT * HS));
    check("vs_low", 32'(n_vs), 32'(2 * VS * HT));
    check("de_high", 32'(n_de), 32'(2 * HD * VD));
    check("fc_2fr", 32'(frame_cnt), 32'd2);

    // Scroll by 3 per frame
    do_reset(5);
    mode = 2'd0; speed = 3'd3; dir = 1'b0; pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run(F);
      check("scroll_off", 32'(dut.offset), 32'(3 * (i + 1)));
    end
    check("scroll_fc", 32'(frame_cnt), 32'd4);

    // Wrap in both directions, xor pattern makes offset visible
    do_reset(5);
    mode = 2'd2; speed = 3'd1; dir = 1'b0;
    run(F);
    check("wrap_pre", 32'(dut.offset), 32'd1);
    speed = 3'd2; dir = 1'b1;
    run(F);
    check("wrap_dn", 32'(dut.offset), 32'h3FF);
    speed = 3'd1; dir = 1'b1;
    run(F);
    check("wrap_pre2", 32'(dut.offset), 32'h3FE);
    speed = 3'd2; dir = 1'b0;
    run(F);
    check("wrap_up", 32'(dut.offset), 32'd0);

    // Mid-frame mode change with pause: bars to frame end, xor after, state frozen
    mode = 2'd0; speed = 3'd1; dir = 1'b0;
    run(F);
    k = 0;
    while (!(((m_t / HT) % VT) == 2 && (m_t % HT) == 0) && k < 2 * F) begin
      step();
      k++;
    end
    check("tear_reach", 32'(k < 2 * F), 32'd1);
    mode = 2'd2; pause = 1'b1; speed = 3'd5;
    run(2 * F);
    check("pause_off", 32'(dut.offset), 32'd1);
    check("pause_fc", 32'(frame_cnt), 32'd5);
    pause = 1'b0;

    // Random frames until frame_cnt reaches 0xC0
    for (int fr = 0; fr < 400 && m_fc != 192; fr++) begin
      int chg;
      chg = int'($urandom_range(0, F - 1));
      for (int i = 0; i < F && m_fc != 192; i++) begin
        if (i == 0 || i == chg) begin
          mode  = 2'($urandom_range(0, 3));
          speed = 3'($urandom_range(0, 7));
          dir   = 1'($urandom_range(0, 1));
          pause = ($urandom_range(0, 7) == 0);
        end
        step();
      end
    end
    check("fc_reach", 32'(frame_cnt), 32'hC0);

    // Colour cycle at frame_cnt 0xC0: solid red in the visible area only
    mode = 2'd3; pause = 1'b1;
    run(F);
    n_red = 0; n_lit = 0;
    for (int i = 0; i < F; i++) begin
      step();
      if ({r, g, b} == 6'b110000) n_red++;
      if ({r, g, b} != 6'b000000) n_lit++;
    end
    check("cyc_red", 32'(n_red), 32'(HD * VD));
    check("cyc_lit", 32'(n_lit), 32'(HD * VD));
    check("cyc_fc", 32'(frame_cnt), 32'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
